// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port general-purpose register file with a write-back
// scoreboard of per-register busy bits.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : same-cycle write data is forwarded to matching read ports
//   undefined : reads reflect registered state only
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  address width, depth = 2**ADDR_W registers
//   NRD     number of combinational read ports (1..4)
//
// Ports
//   clk        rising-edge clock for all state
//   resetn     asynchronous active-low clear of all data and busy bits
//   raddr      NRD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata      NRD packed read data, port i at [i*DATA_W +: DATA_W]
//   rbusy      busy flag of each read address
//   we0/waddr0/wdata0  write port 0 (lower priority)
//   we1/waddr1/wdata1  write port 1 (wins a same-address collision)
//   set_valid/set_addr mark a destination register busy at the next edge
//   busy_cnt   registered population count of the busy vector
//
// Register 0 is hardwired to zero and can never become busy.

module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic                  set_valid,
  input  logic [ADDR_W-1:0]     set_addr,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  busy_nxt_s;
  logic [ADDR_W:0]   busy_cnt_r;

  // Effective enables: anything aimed at register 0 is discarded up front.
  logic we0_eff_s;
  logic we1_eff_s;
  logic set_eff_s;

  assign we0_eff_s = we0 && (waddr0 != {ADDR_W{1'b0}});
  assign we1_eff_s = we1 && (waddr1 != {ADDR_W{1'b0}});
  assign set_eff_s = set_valid && (set_addr != {ADDR_W{1'b0}});

  // Population count of a busy vector.
  function automatic logic [ADDR_W:0] count_ones(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = {(ADDR_W+1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, v[k]};
    end
    return cnt;
  endfunction

  // Next busy vector: a write retires its register, but a set in the same
  // cycle means a newer producer is outstanding, so set wins over clear.
  always_comb begin
    busy_nxt_s = {DEPTH{1'b0}};
    for (int j = 1; j < DEPTH; j++) begin
      busy_nxt_s[j] = (set_eff_s && (set_addr == ADDR_W'(j))) ||
                      (busy_r[j] &&
                       !(we0_eff_s && (waddr0 == ADDR_W'(j))) &&
                       !(we1_eff_s && (waddr1 == ADDR_W'(j))));
    end
  end

  // Data array update; port 1 takes precedence on an address collision.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_r[j] <= {DATA_W{1'b0}};
      end
    end else begin
      mem_r[0] <= {DATA_W{1'b0}};
      for (int j = 1; j < DEPTH; j++) begin
        if (we1_eff_s && (waddr1 == ADDR_W'(j))) begin
          mem_r[j] <= wdata1;
        end else if (we0_eff_s && (waddr0 == ADDR_W'(j))) begin
          mem_r[j] <= wdata0;
        end else begin
          mem_r[j] <= mem_r[j];
        end
      end
    end
  end

  // Busy vector and its registered population count move together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_r     <= {DEPTH{1'b0}};
      busy_cnt_r <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= count_ones(busy_nxt_s);
    end
  end

  assign busy_cnt = busy_cnt_r;

  // Read ports. mem_r[0] and busy_r[0] are held at zero, so register 0
  // needs no special casing on the read side.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    assign ra_s = raddr[gi*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    logic hit1_s;
    logic hit0_s;
    logic hold_s;
    // The effective enables already exclude register 0.
    assign hit1_s = we1_eff_s && (waddr1 == ra_s);
    assign hit0_s = we0_eff_s && (waddr0 == ra_s);
    // A same-cycle set of the forwarded register keeps the stored busy bit
    // visible; the set itself only takes effect at the next edge.
    assign hold_s = set_eff_s && (set_addr == ra_s);

    assign rdata[gi*DATA_W +: DATA_W] = hit1_s ? wdata1 :
                                        hit0_s ? wdata0 : mem_r[ra_s];
    assign rbusy[gi] = (hit1_s || hit0_s) ? (hold_s && busy_r[ra_s])
                                          : busy_r[ra_s];
`else
    assign rdata[gi*DATA_W +: DATA_W] = mem_r[ra_s];
    assign rbusy[gi]                  = busy_r[ra_s];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (DATA_W=64, ADDR_W=4, NRD=4).
// Stimulus pushes expected read results into a scoreboard queue; a monitor
// on the falling edge pops and compares against the live DUT outputs.

module tb_regfile_mp;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam int NREG = 1 << AW;

  logic              clk;
  logic              resetn;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic              we0;
  logic [AW-1:0]     waddr0;
  logic [DW-1:0]     wdata0;
  logic              we1;
  logic [AW-1:0]     waddr1;
  logic [DW-1:0]     wdata1;
  logic              set_valid;
  logic [AW-1:0]     set_addr;
  logic [AW:0]       busy_cnt;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .set_valid(set_valid), .set_addr(set_addr), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    busy;
    logic [AW:0]      cnt;
    string            nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int ntests = 0;
  int nfail  = 0;

  // Reference state: contents and pending flag per register.
  logic [DW-1:0] mem_m  [NREG];
  bit            busy_m [NREG];

  task automatic chk(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int j = 0; j < NREG; j++) begin
      mem_m[j]  = '0;
      busy_m[j] = 1'b0;
    end
  endfunction

  // Expected outputs for the inputs currently applied.
  function automatic exp_t model_exp(input string nm);
    exp_t e;
    int   c;
    e.nm = nm;
    c = 0;
    for (int j = 0; j < NREG; j++) c += busy_m[j] ? 1 : 0;
    e.cnt = c[AW:0];
    for (int i = 0; i < NR; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          b;
      a = raddr[i*AW +: AW];
      d = mem_m[a];
      b = busy_m[a];
`ifdef REGFILE_BYPASS_EN
      if (a != 0 && ((we1 && waddr1 == a) || (we0 && waddr0 == a))) begin
        d = (we1 && waddr1 == a) ? wdata1 : wdata0;
        b = (set_valid && set_addr == a) ? busy_m[a] : 1'b0;
      end
`endif
      e.data[i*DW +: DW] = d;
      e.busy[i]          = b;
    end
    return e;
  endfunction

  // Apply the effect of the current inputs at a clock edge.
  function automatic void model_commit();
    if (we0 && waddr0 != 0) begin mem_m[waddr0] = wdata0; busy_m[waddr0] = 1'b0; end
    if (we1 && waddr1 != 0) begin mem_m[waddr1] = wdata1; busy_m[waddr1] = 1'b0; end
    if (set_valid && set_addr != 0) busy_m[set_addr] = 1'b1;
  endfunction

  function automatic logic [NR*AW-1:0] all_ports(input logic [AW-1:0] a);
    return {NR{a}};
  endfunction

  task automatic idle_inputs();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    set_valid = 1'b0; set_addr = '0;
  endtask

  // One cycle: called just after a rising edge, returns just after the next.
  task automatic drive(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic s, input logic [AW-1:0] sa,
                       input logic [NR*AW-1:0] ra, input string nm);
    we0 = w0; waddr0 = a0; wdata0 = d0;
    we1 = w1; waddr1 = a1; wdata1 = d1;
    set_valid = s; set_addr = sa;
    raddr = ra;
    sb_q.push_back(model_exp(nm));
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic rd(input logic [NR*AW-1:0] ra, input string nm);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, ra, nm);
  endtask

  // Monitor: compare whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk({mon_e.nm, "_rdata"}, rdata, mon_e.data);
      chk({mon_e.nm, "_rbusy"}, NR*DW'(rbusy), NR*DW'(mon_e.busy));
      chk({mon_e.nm, "_cnt"}, NR*DW'(busy_cnt), NR*DW'(mon_e.cnt));
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NR*AW-1:0] ra;
    logic [DW-1:0]    d0, d1;

    idle_inputs();
    raddr  = all_ports(4'd5);
    resetn = 1'b0;
    model_clear();
    #2;
    chk("por_rdata", rdata, '0);
    chk("por_rbusy", NR*DW'(rbusy), '0);
    chk("por_cnt", NR*DW'(busy_cnt), '0);
    @(posedge clk); #1;
    resetn = 1'b1;

    rd({4'd3, 4'd2, 4'd1, 4'd0}, "after_reset");

    // Register 0: writes and sets are discarded.
    drive(1'b1, 4'd0, 64'hFFFF_FFFF, 1'b1, 4'd0, 64'hFFFF_FFFF, 1'b1, 4'd0, all_ports(4'd0), "r0_wr");
    rd(all_ports(4'd0), "r0_rd");

    // Collision on r7: port 1 wins.
    drive(1'b1, 4'd7, 64'h11, 1'b1, 4'd7, 64'h22, 1'b0, '0, all_ports(4'd7), "coll_wr");
    rd(all_ports(4'd7), "coll_rd");

    // Scoreboard set, hold, clear, and same-cycle set+write.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd3, all_ports(4'd3), "sb_set");
    rd(all_ports(4'd3), "sb_busy");
    rd(all_ports(4'd3), "sb_hold");
    drive(1'b1, 4'd3, 64'h33, 1'b0, '0, '0, 1'b0, '0, all_ports(4'd3), "sb_wr");
    rd(all_ports(4'd3), "sb_clr");
    drive(1'b0, '0, '0, 1'b1, 4'd9, 64'h99, 1'b1, 4'd9, all_ports(4'd9), "sb_setwr");
    rd(all_ports(4'd9), "sb_setwr_rd");
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd9, all_ports(4'd9), "sb_reset_busy");
    drive(1'b1, 4'd9, 64'h9A, 1'b0, '0, '0, 1'b1, 4'd9, all_ports(4'd9), "sb_byp_set");

    // Same-cycle visibility of a write (forwarded only with the bypass).
    drive(1'b1, 4'd4, 64'h1234, 1'b0, '0, '0, 1'b0, '0, all_ports(4'd4), "byp_wr");
    rd(all_ports(4'd4), "byp_rd");

    // Fill every register and mark each busy, then read all back.
    for (int j = 0; j < NREG; j++) begin
      d0 = 64'h1000_0000_0000_0000 + 64'(j) * 64'h0101_0101;
      drive(1'b1, 4'(j), d0, 1'b0, '0, '0, 1'b1, 4'(j), all_ports(4'(j)), "fill");
    end
    for (int j = 0; j < NREG / NR; j++) begin
      rd({4'(4*j+3), 4'(4*j+2), 4'(4*j+1), 4'(4*j)}, "fill_rd");
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      ra = (NR*AW)'($urandom);
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      drive(1'($urandom), 4'($urandom), d0, 1'($urandom), 4'($urandom), d1,
            ($urandom_range(0, 3) == 0), 4'($urandom), ra, "rand");
    end

    // Mid-cycle asynchronous reset after writing r5.
    drive(1'b1, 4'd5, 64'hDEAD_BEEF, 1'b0, '0, '0, 1'b1, 4'd6, all_ports(4'd5), "rst_pre");
    idle_inputs();
    raddr = all_ports(4'd5);
    #2;
    resetn = 1'b0;
    model_clear();
    #1;
    chk("arst_rdata", rdata, '0);
    chk("arst_rbusy", NR*DW'(rbusy), '0);
    chk("arst_cnt", NR*DW'(busy_cnt), '0);
    // Writes and sets while reset is low are lost.
    we0 = 1'b1; waddr0 = 4'd8; wdata0 = 64'h88;
    set_valid = 1'b1; set_addr = 4'd8;
    @(posedge clk); #1;
    idle_inputs();
    resetn = 1'b1;
    rd(all_ports(4'd8), "rst_lost");
    rd({4'd5, 4'd6, 4'd7, 4'd9}, "rst_after");

    chk("sb_drain", NR*DW'(sb_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
